win_evaluator: RTL and testbench
================================

// Module: win_evaluator
// PURPOSE
//   Sequential, parametrised win/payout evaluator for N-reel slot spins; successor to the combinational win stage.
//   Sits between the spin stage and the play/score stage: captures a spin, checks reel matches one reel per cycle,
//   pays out with saturation, and owns the progressive jackpot register.
//   Start/Busy/Done handshake; one evaluation in flight at a time.
// PARAMETERS
//   NUM_REELS      3      reel count, >=2
//   SYM_W          4      bits per reel symbol
//   SCORE_W        17     score/jackpot width
//   JACKPOT_SYM    7      symbol that, on all reels, wins the jackpot
//   PAY_SINGLE     200    payout for a non-jackpot match, single bet
//   PAY_MAX        1000   payout for a non-jackpot match, max bet
//   JACKPOT_SEED   5000   jackpot value after reset and after a jackpot win
//   CONTRIB_SINGLE 10     jackpot growth per losing/normal spin, single bet
//   CONTRIB_MAX    50     jackpot growth per losing/normal spin, max bet
// PORTS
//   Clock        in   1                  rising-edge clock
//   Reset        in   1                  synchronous, active-high
//   Start        in   1                  request evaluation; sampled only in IDLE
//   PlayerSpin   in   NUM_REELS*SYM_W    reel i = PlayerSpin[(NUM_REELS-i)*SYM_W-1 -: SYM_W]; reel 0 is at the MSBs
//   PlayerIn     in   SCORE_W            player score before this spin
//   PlayerBet    in   1                  1 = max bet, 0 = single bet
//   Busy         out  1                  high in every state except IDLE
//   Done         out  1                  one-cycle pulse; results valid in that cycle and held afterwards
//   PlayerOut    out  SCORE_W            updated player score
//   SpinType     out  2                  00 = nothing, 01 = win, 11 = jackpot (10 never driven)
//   JackpotValue out  SCORE_W            current progressive jackpot
// BEHAVIOUR
//   Reset: state IDLE; Busy=0, Done=0, PlayerOut=0, SpinType=00, JackpotValue=JACKPOT_SEED; reel counter 0.
//     Reset has priority in any state and aborts an evaluation with no score or jackpot update.
//   FSM: IDLE -> COMPARE -> PAYOUT -> DONE -> IDLE.
//   IDLE: Start=1 registers PlayerSpin, PlayerIn and PlayerBet; sets match=1 and counter=1; goes to COMPARE.
//     Inputs are don't-care after this capture cycle.
//   COMPARE: one cycle per reel i = 1..NUM_REELS-1; match &= (reel i == reel 0).
//     After i = NUM_REELS-1, go to PAYOUT.
//   PAYOUT (1 cycle):
//     jackpot = match & (reel 0 == JACKPOT_SYM).
//     jackpot: add = JackpotValue; JackpotValue <= JACKPOT_SEED; SpinType <= 11.
//     match, not jackpot: add = PlayerBet ? PAY_MAX : PAY_SINGLE; SpinType <= 01.
//     no match: add = 0; SpinType <= 00.
//     Not jackpot: JackpotValue += PlayerBet ? CONTRIB_MAX : CONTRIB_SINGLE.
//     PlayerOut <= PlayerIn + add.
//     All additions saturate at 2^SCORE_W-1; never wrap.
//   DONE (1 cycle): Done=1, then IDLE. PlayerOut, SpinType and JackpotValue hold until the next PAYOUT.
//   Latency: Start in cycle 0 -> Done in cycle NUM_REELS+1. Throughput: one spin per NUM_REELS+2 cycles.
//   Start while Busy=1 is ignored, not queued. Start held high continuously re-triggers in each IDLE cycle.
//   Payout parameters wider than SCORE_W are a configuration error; the implementation flags it with an elaboration check.
// TESTING (defaults, fresh reset; cycle 0 = Start cycle)
//   Spin 12'h777, Bet=1, In=100 -> Done at cycle 4; SpinType=11; PlayerOut=5100; JackpotValue=5000.
//   Spin 12'h333, Bet=0, In=500 -> PlayerOut=700; SpinType=01; JackpotValue=5010.
//   Spin 12'h372, Bet=1, In=42 -> PlayerOut=42; SpinType=00; JackpotValue=5050.
//   Spin 12'h555, Bet=1, In=17'h1FFFF-100 -> PlayerOut=17'h1FFFF (saturated). Then 2700 max-bet losses -> JackpotValue sticks at 17'h1FFFF.
//   Start pulsed at cycle 2 is ignored; Reset at cycle 2 -> no Done; PlayerOut=0; JackpotValue=5000; Busy=0 at cycle 3.
//   NUM_REELS=5, SYM_W=3: Spin 15'o77777 -> jackpot, Done at cycle 6. 15'o77776 -> SpinType=00. Start held high -> Done every 7 cycles.

Source files
------------

// File: rtl/win_evaluator_if.sv
// Spin request / result bundle between the spin stage, the win evaluator and the score stage.
interface win_evaluator_if #(
  parameter int unsigned NUM_REELS = 3,
  parameter int unsigned SYM_W     = 4,
  parameter int unsigned SCORE_W   = 17
);
  logic                         Start;
  logic [NUM_REELS*SYM_W-1:0]   PlayerSpin;
  logic [SCORE_W-1:0]           PlayerIn;
  logic                         PlayerBet;
  logic                         Busy;
  logic                         Done;
  logic [SCORE_W-1:0]           PlayerOut;
  logic [1:0]                   SpinType;
  logic [SCORE_W-1:0]           JackpotValue;

  modport master (
    output Start, PlayerSpin, PlayerIn, PlayerBet,
    input  Busy, Done, PlayerOut, SpinType, JackpotValue
  );

  modport slave (
    input  Start, PlayerSpin, PlayerIn, PlayerBet,
    output Busy, Done, PlayerOut, SpinType, JackpotValue
  );
endinterface

// File: rtl/win_evaluator.sv
// Sequential win/payout evaluator: compares one reel per cycle against reel 0, pays out with
// saturation and owns the progressive jackpot register.
module win_evaluator #(
  parameter int unsigned NUM_REELS      = 3,
  parameter int unsigned SYM_W          = 4,
  parameter int unsigned SCORE_W        = 17,
  parameter int unsigned JACKPOT_SYM    = 7,
  parameter int unsigned PAY_SINGLE     = 200,
  parameter int unsigned PAY_MAX        = 1000,
  parameter int unsigned JACKPOT_SEED   = 5000,
  parameter int unsigned CONTRIB_SINGLE = 10,
  parameter int unsigned CONTRIB_MAX    = 50
) (
  input logic            Clock,
  input logic            Reset,
  win_evaluator_if.slave bus
);

  localparam int unsigned     SPIN_W    = NUM_REELS * SYM_W;
  localparam int unsigned     CNT_W     = $clog2(NUM_REELS);
  localparam longint unsigned SCORE_MAX = (64'd1 << SCORE_W) - 64'd1;
  localparam longint unsigned SYM_MAX   = (64'd1 << SYM_W) - 64'd1;

  // Configuration sanity: constants must fit the datapath they feed.
  if (NUM_REELS < 2) begin : gBadReels
    $error("win_evaluator: NUM_REELS must be at least 2");
  end
  if (longint'(JACKPOT_SYM) > SYM_MAX) begin : gBadSym
    $error("win_evaluator: JACKPOT_SYM does not fit in SYM_W bits");
  end
  if (longint'(PAY_SINGLE) > SCORE_MAX || longint'(PAY_MAX) > SCORE_MAX ||
      longint'(JACKPOT_SEED) > SCORE_MAX || longint'(CONTRIB_SINGLE) > SCORE_MAX ||
      longint'(CONTRIB_MAX) > SCORE_MAX) begin : gBadPay
    $error("win_evaluator: payout constants wider than SCORE_W");
  end

  localparam logic [SYM_W-1:0]   JACKPOT_SYM_V    = SYM_W'(JACKPOT_SYM);
  localparam logic [SCORE_W-1:0] PAY_SINGLE_V     = SCORE_W'(PAY_SINGLE);
  localparam logic [SCORE_W-1:0] PAY_MAX_V        = SCORE_W'(PAY_MAX);
  localparam logic [SCORE_W-1:0] JACKPOT_SEED_V   = SCORE_W'(JACKPOT_SEED);
  localparam logic [SCORE_W-1:0] CONTRIB_SINGLE_V = SCORE_W'(CONTRIB_SINGLE);
  localparam logic [SCORE_W-1:0] CONTRIB_MAX_V    = SCORE_W'(CONTRIB_MAX);
  localparam logic [CNT_W-1:0]   LAST_REEL        = CNT_W'(NUM_REELS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    PAYOUT  = 2'd2,
    DONE    = 2'd3
  } stateType;

  stateType           state, stateNext;
  logic [CNT_W-1:0]   reelCnt, reelCntNext;
  logic [SPIN_W-1:0]  spinQ, spinNext;
  logic [SCORE_W-1:0] inQ, inNext;
  logic               betQ, betNext;
  logic               matchQ, matchNext;
  logic               busyQ, doneQ;
  logic [SCORE_W-1:0] outQ, outNext;
  logic [1:0]         typeQ, typeNext;
  logic [SCORE_W-1:0] jackQ, jackNext;
  logic [SCORE_W-1:0] addAmount;
  logic [SYM_W-1:0]   reels [NUM_REELS];

  // Saturating add: clamps at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] satAdd(input logic [SCORE_W-1:0] a,
                                                input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

  // Reel 0 sits at the MSBs of the captured spin.
  for (genvar g = 0; g < NUM_REELS; g++) begin : gReel
    assign reels[g] = spinQ[(NUM_REELS-g)*SYM_W-1 -: SYM_W];
  end

  always_comb begin
    stateNext   = state;
    reelCntNext = reelCnt;
    spinNext    = spinQ;
    inNext      = inQ;
    betNext     = betQ;
    matchNext   = matchQ;
    outNext     = outQ;
    typeNext    = typeQ;
    jackNext    = jackQ;
    addAmount   = '0;

    case (state)
      IDLE: begin
        if (bus.Start) begin
          spinNext    = bus.PlayerSpin;
          inNext      = bus.PlayerIn;
          betNext     = bus.PlayerBet;
          matchNext   = 1'b1;
          reelCntNext = CNT_W'(1);
          stateNext   = COMPARE;
        end
      end
      COMPARE: begin
        matchNext = matchQ & (reels[reelCnt] == reels[0]);
        if (reelCnt == LAST_REEL) begin
          stateNext = PAYOUT;
        end else begin
          reelCntNext = reelCnt + CNT_W'(1);
        end
      end
      PAYOUT: begin
        if (matchQ && (reels[0] == JACKPOT_SYM_V)) begin
          addAmount = jackQ;
          jackNext  = JACKPOT_SEED_V;
          typeNext  = 2'b11;
        end else begin
          if (matchQ) begin
            addAmount = betQ ? PAY_MAX_V : PAY_SINGLE_V;
            typeNext  = 2'b01;
          end else begin
            typeNext  = 2'b00;
          end
          jackNext = satAdd(jackQ, betQ ? CONTRIB_MAX_V : CONTRIB_SINGLE_V);
        end
        outNext   = satAdd(inQ, addAmount);
        stateNext = DONE;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Busy/Done are registered from the next state so they line up with the state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      reelCnt <= '0;
      spinQ   <= '0;
      inQ     <= '0;
      betQ    <= 1'b0;
      matchQ  <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      outQ    <= '0;
      typeQ   <= 2'b00;
      jackQ   <= JACKPOT_SEED_V;
    end else begin
      state   <= stateNext;
      reelCnt <= reelCntNext;
      spinQ   <= spinNext;
      inQ     <= inNext;
      betQ    <= betNext;
      matchQ  <= matchNext;
      busyQ   <= (stateNext != IDLE);
      doneQ   <= (stateNext == DONE);
      outQ    <= outNext;
      typeQ   <= typeNext;
      jackQ   <= jackNext;
    end
  end

  assign bus.Busy         = busyQ;
  assign bus.Done         = doneQ;
  assign bus.PlayerOut    = outQ;
  assign bus.SpinType     = typeQ;
  assign bus.JackpotValue = jackQ;

endmodule

// File: tb/tb_win_evaluator.sv
// Directed bench for win_evaluator: default 3-reel instance plus a 5-reel, 3-bit-symbol instance.
`timescale 1ns/1ps

module tb_win_evaluator;

  logic Clock;
  logic Reset;
  int   nCmp;
  int   nBad;

  win_evaluator_if #(.NUM_REELS(3), .SYM_W(4), .SCORE_W(17)) b3 ();
  win_evaluator_if #(.NUM_REELS(5), .SYM_W(3), .SCORE_W(17)) b5 ();

  win_evaluator #(.NUM_REELS(3), .SYM_W(4), .SCORE_W(17)) dut3 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (b3.slave)
  );

  win_evaluator #(.NUM_REELS(5), .SYM_W(3), .SCORE_W(17)) dut5 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (b5.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Compare one observed value against its expectation and tally the result.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  // Start in cycle 0; returns the cycle in which Done was seen, or -1 on timeout.
  task automatic spin3(input logic [11:0] s, input logic [16:0] pin, input logic bet,
                       output int lat);
    @(negedge Clock);
    b3.Start      = 1'b1;
    b3.PlayerSpin = s;
    b3.PlayerIn   = pin;
    b3.PlayerBet  = bet;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clock);
      b3.Start = 1'b0;
      if (b3.Done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic spin5(input logic [14:0] s, input logic [16:0] pin, input logic bet,
                       output int lat);
    @(negedge Clock);
    b5.Start      = 1'b1;
    b5.PlayerSpin = s;
    b5.PlayerIn   = pin;
    b5.PlayerBet  = bet;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clock);
      b5.Start = 1'b0;
      if (b5.Done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int doneSeen;
    int doneAt [3];

    nCmp = 0;
    nBad = 0;
    Reset = 1'b1;
    b3.Start = 1'b0; b3.PlayerSpin = '0; b3.PlayerIn = '0; b3.PlayerBet = 1'b0;
    b5.Start = 1'b0; b5.PlayerSpin = '0; b5.PlayerIn = '0; b5.PlayerBet = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    // Reset state
    chk("rst_busy", b3.Busy, 0);
    chk("rst_done", b3.Done, 0);
    chk("rst_out", b3.PlayerOut, 0);
    chk("rst_type", b3.SpinType, 0);
    chk("rst_jack", b3.JackpotValue, 5000);

    // Jackpot, max bet
    doReset();
    spin3(12'h777, 17'd100, 1'b1, lat);
    chk("jp_latency", lat, 4);
    chk("jp_type", b3.SpinType, 3);
    chk("jp_out", b3.PlayerOut, 5100);
    chk("jp_jack", b3.JackpotValue, 5000);
    @(negedge Clock);
    chk("jp_done_pulse", b3.Done, 0);
    chk("jp_busy_idle", b3.Busy, 0);
    chk("jp_out_hold", b3.PlayerOut, 5100);

    // Normal win, single bet
    doReset();
    spin3(12'h333, 17'd500, 1'b0, lat);
    chk("win_latency", lat, 4);
    chk("win_out", b3.PlayerOut, 700);
    chk("win_type", b3.SpinType, 1);
    chk("win_jack", b3.JackpotValue, 5010);

    // Loss, max bet
    doReset();
    spin3(12'h372, 17'd42, 1'b1, lat);
    chk("loss_out", b3.PlayerOut, 42);
    chk("loss_type", b3.SpinType, 0);
    chk("loss_jack", b3.JackpotValue, 5050);

    // Only the last reel differs
    spin3(12'h337, 17'd5, 1'b0, lat);
    chk("lastreel_out", b3.PlayerOut, 5);
    chk("lastreel_type", b3.SpinType, 0);
    chk("lastreel_jack", b3.JackpotValue, 5060);

    // Player score saturation, then jackpot saturation
    doReset();
    spin3(12'h555, 17'h1FFFF - 17'd100, 1'b1, lat);
    chk("sat_out", b3.PlayerOut, 17'h1FFFF);
    chk("sat_type", b3.SpinType, 1);
    chk("sat_jack", b3.JackpotValue, 5050);
    for (int i = 0; i < 2700; i++) begin
      spin3(12'h372, 17'(i), 1'b1, lat);
      if (i == 99) begin
        chk("grow_jack_100", b3.JackpotValue, 10050);
        chk("grow_out_100", b3.PlayerOut, 99);
      end
    end
    chk("sat_jack_stick", b3.JackpotValue, 17'h1FFFF);
    spin3(12'h777, 17'd1, 1'b0, lat);
    chk("satjp_out", b3.PlayerOut, 17'h1FFFF);
    chk("satjp_type", b3.SpinType, 3);
    chk("satjp_jack", b3.JackpotValue, 5000);

    // Start while busy is ignored
    doReset();
    @(negedge Clock);
    b3.Start = 1'b1; b3.PlayerSpin = 12'h333; b3.PlayerIn = 17'd500; b3.PlayerBet = 1'b0;
    @(negedge Clock);
    b3.Start = 1'b0;
    chk("ign_busy_c1", b3.Busy, 1);
    @(negedge Clock);
    b3.Start = 1'b1; b3.PlayerSpin = 12'h777; b3.PlayerIn = 17'd9; b3.PlayerBet = 1'b1;
    @(negedge Clock);
    b3.Start = 1'b0;
    @(negedge Clock);
    chk("ign_done_c4", b3.Done, 1);
    chk("ign_out", b3.PlayerOut, 700);
    chk("ign_type", b3.SpinType, 1);
    chk("ign_jack", b3.JackpotValue, 5010);
    @(negedge Clock);
    chk("ign_busy_c5", b3.Busy, 0);
    doneSeen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clock);
      if (b3.Done) doneSeen++;
    end
    chk("ign_no_extra_done", doneSeen, 0);

    // Reset aborts an evaluation
    doReset();
    spin3(12'h372, 17'd3, 1'b0, lat);
    chk("abort_pre_jack", b3.JackpotValue, 5010);
    @(negedge Clock);
    b3.Start = 1'b1; b3.PlayerSpin = 12'h777; b3.PlayerIn = 17'd1234; b3.PlayerBet = 1'b1;
    @(negedge Clock);
    b3.Start = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("abort_busy_c3", b3.Busy, 0);
    chk("abort_out", b3.PlayerOut, 0);
    chk("abort_jack", b3.JackpotValue, 5000);
    chk("abort_type", b3.SpinType, 0);
    doneSeen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clock);
      if (b3.Done) doneSeen++;
    end
    chk("abort_no_done", doneSeen, 0);

    // Five-reel instance
    doReset();
    spin5(15'o77777, 17'd0, 1'b0, lat);
    chk("r5_jp_latency", lat, 6);
    chk("r5_jp_type", b5.SpinType, 3);
    chk("r5_jp_out", b5.PlayerOut, 5000);
    spin5(15'o77776, 17'd8, 1'b0, lat);
    chk("r5_loss_type", b5.SpinType, 0);
    chk("r5_loss_out", b5.PlayerOut, 8);
    chk("r5_loss_jack", b5.JackpotValue, 5010);

    // Start held high re-triggers every NUM_REELS+2 cycles
    doReset();
    @(negedge Clock);
    b5.Start = 1'b1; b5.PlayerSpin = 15'o77776; b5.PlayerIn = 17'd0; b5.PlayerBet = 1'b0;
    doneSeen = 0;
    doneAt[0] = -1; doneAt[1] = -1; doneAt[2] = -1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge Clock);
      if (b5.Done) begin
        if (doneSeen < 3) doneAt[doneSeen] = c;
        doneSeen++;
      end
    end
    b5.Start = 1'b0;
    chk("held_done_count", doneSeen, 3);
    chk("held_done_0", doneAt[0], 6);
    chk("held_done_1", doneAt[1], 13);
    chk("held_done_2", doneAt[2], 20);
    chk("held_jack", b5.JackpotValue, 5030);
    repeat (10) @(negedge Clock);
    chk("held_idle_after", b5.Busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
